// File: rtl/janus_mem_pkg.sv
// janus_mem_pkg: shared state/owner encodings and defaults for the RAM write path
package janus_mem_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_ACK   = 2'd2
   } state_t;
   typedef enum logic {
      OWN_RB = 1'b0,
      OWN_PC = 1'b1
   } owner_t;
   localparam int DEF_TIMEOUT_CYCLES = 16;
   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_ADDR_WIDTH     = 32;
endpackage

// File: rtl/dob_wdog.sv
// dob_wdog: write watchdog counter
//   clk, rst_b : clock, async active-low reset
//   clr        : force counter to 0 (has priority over en)
//   en         : count one cycle
//   expired    : counter has reached TIMEOUT_CYCLES-1
module dob_wdog #(
   parameter int TIMEOUT_CYCLES = janus_mem_pkg::DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_b,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   end
   assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/dob_mux.sv
// dob_mux: arbitrates PC/RB store requests and sequences one RAM write at a time
//   clk, rst_b             : clock, async active-low reset
//   rb_wr_req/addr/data    : register-bank store request (level, held until rb_wr_ack)
//   pc_wr_req/addr/data    : PC push request (level, held until pc_wr_ack); wins over RB
//   ram_we_ack             : RAM write complete, only looked at while writing
//   dob, dob_addr, ram_we  : registered write bus to RAM
//   rb_wr_ack, pc_wr_ack   : one-cycle acknowledge to the serviced requester
//   dob_err                : one-cycle, alongside the ack of a watchdog-aborted write
module dob_mux
   import janus_mem_pkg::*;
#(
   parameter int PA_DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int PA_ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic                     rb_wr_req,
   input  logic [PA_ADDR_WIDTH-1:0] rb_wr_addr,
   input  logic [PA_DATA_WIDTH-1:0] rb_wr_data,
   input  logic                     pc_wr_req,
   input  logic [PA_ADDR_WIDTH-1:0] pc_wr_addr,
   input  logic [PA_DATA_WIDTH-1:0] pc_wr_data,
   input  logic                     ram_we_ack,
   output logic [PA_DATA_WIDTH-1:0] dob,
   output logic [PA_ADDR_WIDTH-1:0] dob_addr,
   output logic                     ram_we,
   output logic                     rb_wr_ack,
   output logic                     pc_wr_ack,
   output logic                     dob_err
);
   state_t                   state, state_nxt;
   owner_t                   owner, owner_nxt;
   logic [PA_DATA_WIDTH-1:0] dob_nxt;
   logic [PA_ADDR_WIDTH-1:0] addr_nxt;
   logic                     we_nxt, rb_ack_nxt, pc_ack_nxt, err_nxt;
   logic                     expired;

   dob_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .clk     (clk),
      .rst_b   (rst_b),
      .clr     (state != ST_WRITE),
      .en      (state == ST_WRITE),
      .expired (expired)
   );

   // All outputs are computed one cycle ahead and registered, so nothing
   // reaches an output combinationally from an input.
   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      dob_nxt    = dob;
      addr_nxt   = dob_addr;
      we_nxt     = 1'b0;
      rb_ack_nxt = 1'b0;
      pc_ack_nxt = 1'b0;
      err_nxt    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pc_wr_req || rb_wr_req) begin
               state_nxt = ST_WRITE;
               owner_nxt = pc_wr_req ? OWN_PC : OWN_RB;
               dob_nxt   = pc_wr_req ? pc_wr_data : rb_wr_data;
               addr_nxt  = pc_wr_req ? pc_wr_addr : rb_wr_addr;
               we_nxt    = 1'b1;
            end
         end
         ST_WRITE: begin
            we_nxt = 1'b1;
            // a RAM ack in the timeout cycle still counts as a clean write
            if (ram_we_ack || expired) begin
               state_nxt  = ST_ACK;
               we_nxt     = 1'b0;
               rb_ack_nxt = (owner == OWN_RB);
               pc_ack_nxt = (owner == OWN_PC);
               err_nxt    = !ram_we_ack;
            end
         end
         ST_ACK:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= ST_IDLE;
         owner     <= OWN_RB;
         dob       <= '0;
         dob_addr  <= '0;
         ram_we    <= 1'b0;
         rb_wr_ack <= 1'b0;
         pc_wr_ack <= 1'b0;
         dob_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         dob       <= dob_nxt;
         dob_addr  <= addr_nxt;
         ram_we    <= we_nxt;
         rb_wr_ack <= rb_ack_nxt;
         pc_wr_ack <= pc_ack_nxt;
         dob_err   <= err_nxt;
      end
   end
endmodule
